// File: rtl/fwd_pkg.sv
// Shared constants for the operand-forwarding / load-use hazard unit.
// Tag layout (MSB..LSB): {valid, wen, is_load, dst[REG_AW-1:0]}.
package fwd_pkg;

  localparam logic [1:0] FWD_SEL_RF  = 2'd0;
  localparam logic [1:0] FWD_SEL_EX  = 2'd1;
  localparam logic [1:0] FWD_SEL_MEM = 2'd2;
  localparam logic [1:0] FWD_SEL_WB  = 2'd3;

  // Number of flag bits carried alongside the destination index in each tag.
  localparam int unsigned TAG_FLAG_W = 3;

  // Width of one stage tag record for a given register index width.
  function automatic int unsigned tag_width(int unsigned reg_aw);
    return reg_aw + TAG_FLAG_W;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID/EX boundary bundle between the pipeline datapath and the hazard unit.
interface fwd_hazard_unit_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 32
);

  logic                      pipe_advance;
  logic                      flush;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src_idx;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_wen;
  logic                      id_is_load;
  logic [NUM_SRC*DATA_W-1:0] id_src_data;
  logic [DATA_W-1:0]         ex_alu_out;
  logic [DATA_W-1:0]         mem_out;
  logic [DATA_W-1:0]         wb_data;
  logic [NUM_SRC*DATA_W-1:0] opnd;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output pipe_advance, flush, id_valid, id_src_idx, id_src_used, id_dst, id_wen, id_is_load,
    output id_src_data, ex_alu_out, mem_out, wb_data,
    input  opnd, fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  pipe_advance, flush, id_valid, id_src_idx, id_src_used, id_dst, id_wen, id_is_load,
    input  id_src_data, ex_alu_out, mem_out, wb_data,
    output opnd, fwd_sel, stall, stall_cnt
  );

endinterface

// File: rtl/fwd_tag_pipe.sv
// Destination-tag shift register mirroring the EX/MEM(/WB) stages.
// Stage 2 (WB) exists only when FWD_WB is set; otherwise it reads as an empty tag.
module fwd_tag_pipe import fwd_pkg::*; #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FWD_WB = 1,
  localparam int unsigned TagW  = tag_width(REG_AW)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 advance_i,
  input  logic                 bubble_i,
  input  logic [TagW-1:0]      tag_i,
  output logic [2:0][TagW-1:0] stg_tag_o
);

  logic [TagW-1:0] s1_d, s1_q, s2_q, s3;

  // A bubble keeps the tag fields but clears the valid bit.
  always_comb begin
    s1_d           = tag_i;
    s1_d[TagW-1]   = tag_i[TagW-1] & ~bubble_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (advance_i) begin
      s1_q <= s1_d;
      s2_q <= s1_q;
    end
  end

  if (FWD_WB != 0) begin : g_wb
    logic [TagW-1:0] s3_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s3_q <= '0;
      end else if (advance_i) begin
        s3_q <= s2_q;
      end
    end
    assign s3 = s3_q;
  end else begin : g_no_wb
    assign s3 = '0;
  end

  assign stg_tag_o = {s3, s2_q, s1_q};

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall detection at the ID/EX boundary.
// Each source resolves to the youngest in-flight producer, falling back to the register file.
module fwd_hazard_unit import fwd_pkg::*; #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned FWD_WB  = 1,
  parameter int unsigned CNT_W   = 32
) (
  input logic               clk,
  input logic               rst_n,
  fwd_hazard_unit_if.slave  bus
);

  localparam int unsigned TagW = tag_width(REG_AW);

  logic [2:0][TagW-1:0]   stg_tag;
  logic [2:0]             stg_valid, stg_wen, stg_load;
  logic [2:0][REG_AW-1:0] stg_dst;

  logic [NUM_SRC-1:0]             ld_hit;
  logic [NUM_SRC-1:0][1:0]        sel_all;
  logic [NUM_SRC-1:0][DATA_W-1:0] opnd_all;

  logic             stall;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  fwd_tag_pipe #(
    .REG_AW (REG_AW),
    .FWD_WB (FWD_WB)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (bus.pipe_advance),
    .bubble_i  (bus.flush | stall),
    .tag_i     ({bus.id_valid, bus.id_wen, bus.id_is_load, bus.id_dst}),
    .stg_tag_o (stg_tag)
  );

  for (genvar s = 0; s < 3; s++) begin : g_unpack
    assign stg_valid[s] = stg_tag[s][REG_AW+2];
    assign stg_wen[s]   = stg_tag[s][REG_AW+1];
    assign stg_load[s]  = stg_tag[s][REG_AW];
    assign stg_dst[s]   = stg_tag[s][REG_AW-1:0];
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_AW-1:0] src;
    logic [2:0]        hit;
    logic [1:0]        sel;
    logic [DATA_W-1:0] val;

    assign src = bus.id_src_idx[k*REG_AW +: REG_AW];

    for (genvar s = 0; s < 3; s++) begin : g_hit
      assign hit[s] = stg_valid[s] & stg_wen[s] & (stg_dst[s] == src) & (src != '0)
                    & bus.id_src_used[k];
    end

    assign ld_hit[k] = hit[0] & stg_load[0];

    // A load in EX has no data yet, so it is skipped and the next-older producer is reported.
    always_comb begin
      sel = FWD_SEL_RF;
      if (hit[0] && !stg_load[0]) begin
        sel = FWD_SEL_EX;
      end else if (hit[1]) begin
        sel = FWD_SEL_MEM;
      end else if (hit[2]) begin
        sel = FWD_SEL_WB;
      end
    end

    always_comb begin
      val = bus.id_src_data[k*DATA_W +: DATA_W];
      unique case (sel)
        FWD_SEL_RF:  val = bus.id_src_data[k*DATA_W +: DATA_W];
        FWD_SEL_EX:  val = bus.ex_alu_out;
        FWD_SEL_MEM: val = bus.mem_out;
        FWD_SEL_WB:  val = bus.wb_data;
        default:     val = bus.id_src_data[k*DATA_W +: DATA_W];
      endcase
    end

    assign sel_all[k]  = sel;
    assign opnd_all[k] = val;
  end

  assign stall = bus.id_valid & ~bus.flush & (|ld_hit);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.pipe_advance && stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.fwd_sel   = sel_all;
  assign bus.opnd      = opnd_all;
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (WB forwarding + wide counter, no WB + 4-bit counter)
// share one stimulus stream and are compared against an in-flight-instruction history model.
module tb_fwd_hazard_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          adv, flush, id_valid, id_wen, id_ld;
  logic [AW-1:0] id_dst;
  logic [AW-1:0] src [NS];
  logic [NS-1:0] used;
  logic [DW-1:0] rf [NS];
  logic [DW-1:0] ex_d, mem_d, wb_d;

  logic [NS*AW-1:0] src_flat;
  logic [NS*DW-1:0] rf_flat;

  always_comb begin
    src_flat = '0;
    rf_flat  = '0;
    for (int k = 0; k < NS; k++) begin
      src_flat[k*AW +: AW] = src[k];
      rf_flat[k*DW +: DW]  = rf[k];
    end
  end

  fwd_hazard_unit_if #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .CNT_W(32)) bus_a ();
  fwd_hazard_unit_if #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .CNT_W(4))  bus_b ();

  assign bus_a.pipe_advance = adv;      assign bus_b.pipe_advance = adv;
  assign bus_a.flush        = flush;    assign bus_b.flush        = flush;
  assign bus_a.id_valid     = id_valid; assign bus_b.id_valid     = id_valid;
  assign bus_a.id_src_idx   = src_flat; assign bus_b.id_src_idx   = src_flat;
  assign bus_a.id_src_used  = used;     assign bus_b.id_src_used  = used;
  assign bus_a.id_dst       = id_dst;   assign bus_b.id_dst       = id_dst;
  assign bus_a.id_wen       = id_wen;   assign bus_b.id_wen       = id_wen;
  assign bus_a.id_is_load   = id_ld;    assign bus_b.id_is_load   = id_ld;
  assign bus_a.id_src_data  = rf_flat;  assign bus_b.id_src_data  = rf_flat;
  assign bus_a.ex_alu_out   = ex_d;     assign bus_b.ex_alu_out   = ex_d;
  assign bus_a.mem_out      = mem_d;    assign bus_b.mem_out      = mem_d;
  assign bus_a.wb_data      = wb_d;     assign bus_b.wb_data      = wb_d;

  fwd_hazard_unit #(
    .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .FWD_WB(1), .CNT_W(32)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  fwd_hazard_unit #(
    .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .FWD_WB(0), .CNT_W(4)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Reference model: the last three accepted instructions, youngest first.
  typedef struct {
    bit v;
    int dst;
    bit wen;
    bit ld;
  } slot_t;

  slot_t   hist[$];
  longint  cnt_a;
  int      cnt_b;
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  longint  cnt_save;

  function automatic void reset_model();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back('{v: 1'b0, dst: 0, wen: 1'b0, ld: 1'b0});
    cnt_a = 0;
    cnt_b = 0;
  endfunction

  function automatic bit produces(slot_t s, int r);
    return s.v && s.wen && (s.dst == r);
  endfunction

  // depth: number of tracked stages (3 with WB forwarding, 2 without)
  function automatic int exp_sel(int k, int depth);
    int r;
    r = int'(src[k]);
    if (!used[k] || r == 0) return 0;
    for (int a = 0; a < depth; a++) begin
      if (produces(hist[a], r)) begin
        if (a == 0 && hist[a].ld) continue;
        return a + 1;
      end
    end
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (!id_valid || flush || !hist[0].ld) return 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (used[k] && src[k] != '0 && produces(hist[0], int'(src[k]))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_opnd(int sel, int k);
    case (sel)
      1:       return ex_d;
      2:       return mem_d;
      3:       return wb_d;
      default: return rf[k];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic settle();
    int sa, sb;
    bit st;
    @(negedge clk);
    st = exp_stall();
    for (int k = 0; k < NS; k++) begin
      sa = exp_sel(k, 3);
      sb = exp_sel(k, 2);
      chk($sformatf("sel_a[%0d]", k), 64'(bus_a.fwd_sel[k*2 +: 2]), 64'(sa));
      chk($sformatf("sel_b[%0d]", k), 64'(bus_b.fwd_sel[k*2 +: 2]), 64'(sb));
      chk($sformatf("opnd_a[%0d]", k), 64'(bus_a.opnd[k*DW +: DW]), 64'(exp_opnd(sa, k)));
      chk($sformatf("opnd_b[%0d]", k), 64'(bus_b.opnd[k*DW +: DW]), 64'(exp_opnd(sb, k)));
    end
    chk("stall_a", 64'(bus_a.stall), 64'(st));
    chk("stall_b", 64'(bus_b.stall), 64'(st));
    chk("cnt_a", 64'(bus_a.stall_cnt), 64'(cnt_a));
    chk("cnt_b", 64'(bus_b.stall_cnt), 64'(cnt_b));
  endtask

  task automatic clk_edge();
    bit st;
    st = exp_stall();
    @(posedge clk);
    if (rst_n && adv) begin
      if (st) begin
        cnt_a++;
        if (cnt_b < 15) cnt_b++;
      end
      hist.push_front('{v: id_valid && !flush && !st, dst: int'(id_dst), wen: id_wen, ld: id_ld});
      void'(hist.pop_back());
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    settle();
    clk_edge();
  endtask

  task automatic instr(input bit v, input int dst, input bit wen, input bit ld,
                       input int s0, input int s1, input logic [1:0] u);
    id_valid = v;
    id_dst   = AW'(dst);
    id_wen   = wen;
    id_ld    = ld;
    src[0]   = AW'(s0);
    src[1]   = AW'(s1);
    used     = u;
  endtask

  initial begin
    adv   = 1'b1;
    flush = 1'b0;
    rf[0] = 32'hDEAD_0000;
    rf[1] = 32'hBEEF_0001;
    ex_d  = 32'h11;
    mem_d = 32'hA5A5;
    wb_d  = 32'h44;
    instr(1, 3, 1, 1, 3, 3, 2'b11);
    reset_model();

    // Held in reset: nothing in flight, everything from the register file.
    step();
    step();
    rst_n = 1'b1;

    // add r3 ; add r4,r3,r3
    instr(1, 3, 1, 0, 0, 0, 2'b00);
    step();
    instr(1, 4, 1, 0, 3, 3, 2'b11);
    settle();
    chk("t1_sel0", 64'(bus_a.fwd_sel[1:0]), 64'd1);
    chk("t1_sel1", 64'(bus_a.fwd_sel[3:2]), 64'd1);
    chk("t1_opnd1", 64'(bus_a.opnd[63:32]), 64'h11);
    clk_edge();

    // lw r5 ; add r6,r5,r1
    instr(1, 5, 1, 1, 0, 0, 2'b00);
    step();
    instr(1, 6, 1, 0, 5, 1, 2'b11);
    settle();
    chk("t2_stall", 64'(bus_a.stall), 64'd1);
    clk_edge();
    chk("t2_cnt", 64'(bus_a.stall_cnt), 64'd1);
    settle();
    chk("t2_sel0", 64'(bus_a.fwd_sel[1:0]), 64'd2);
    chk("t2_opnd0", 64'(bus_a.opnd[31:0]), 64'hA5A5);
    chk("t2_nostall", 64'(bus_a.stall), 64'd0);
    clk_edge();

    // r3 produced in both EX and MEM: youngest wins
    ex_d  = 32'h33;
    mem_d = 32'h22;
    instr(1, 3, 1, 0, 0, 0, 2'b00);
    step();
    step();
    instr(1, 8, 1, 0, 3, 3, 2'b01);
    settle();
    chk("t3_sel_ex", 64'(bus_a.fwd_sel[1:0]), 64'd1);
    chk("t3_opnd_ex", 64'(bus_a.opnd[31:0]), 64'h33);
    clk_edge();
    // r3 only in WB
    instr(1, 3, 1, 0, 0, 0, 2'b00);
    step();
    instr(1, 9, 0, 0, 0, 0, 2'b00);
    step();
    step();
    instr(1, 8, 1, 0, 3, 3, 2'b01);
    settle();
    chk("t3_sel_wb_a", 64'(bus_a.fwd_sel[1:0]), 64'd3);
    chk("t3_sel_wb_b", 64'(bus_b.fwd_sel[1:0]), 64'd0);
    chk("t3_opnd_wb_b", 64'(bus_b.opnd[31:0]), 64'hDEAD_0000);
    clk_edge();

    // r0 never forwards, load to r0 never stalls
    instr(1, 0, 1, 0, 0, 0, 2'b00);
    step();
    instr(1, 10, 1, 0, 0, 0, 2'b11);
    settle();
    chk("t4_sel_r0", 64'(bus_a.fwd_sel), 64'd0);
    clk_edge();
    instr(1, 0, 1, 1, 0, 0, 2'b00);
    step();
    instr(1, 10, 1, 0, 0, 0, 2'b11);
    settle();
    chk("t4_stall_r0", 64'(bus_a.stall), 64'd0);
    clk_edge();

    // load-use with the pipe frozen, then flushed
    instr(1, 7, 1, 1, 0, 0, 2'b00);
    step();
    instr(1, 11, 1, 0, 7, 2, 2'b11);
    adv = 1'b0;
    cnt_save = cnt_a;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t5_hold_stall", 64'(bus_a.stall), 64'd1);
      clk_edge();
      chk("t5_hold_cnt", 64'(bus_a.stall_cnt), 64'(cnt_save));
    end
    adv   = 1'b1;
    flush = 1'b1;
    settle();
    chk("t5_flush_stall", 64'(bus_a.stall), 64'd0);
    clk_edge();
    flush = 1'b0;
    settle();
    chk("t5_after_flush_sel", 64'(bus_a.fwd_sel[1:0]), 64'd2);
    clk_edge();

    // 20 load-use stalls saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      instr(1, 9, 1, 1, 0, 0, 2'b00);
      step();
      instr(1, 12, 1, 0, 9, 0, 2'b01);
      step();
      step();
    end
    chk("t6_sat", 64'(bus_b.stall_cnt), 64'd15);

    // async reset with a load-use pending
    instr(1, 13, 1, 1, 0, 0, 2'b00);
    step();
    instr(1, 14, 1, 0, 13, 13, 2'b11);
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("t6_rst_cnt_a", 64'(bus_a.stall_cnt), 64'd0);
    chk("t6_rst_cnt_b", 64'(bus_b.stall_cnt), 64'd0);
    chk("t6_rst_sel", 64'(bus_a.fwd_sel), 64'd0);
    chk("t6_rst_stall", 64'(bus_a.stall), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // random traffic over a small register window to provoke hits
    for (int i = 0; i < 400; i++) begin
      adv      = ($urandom_range(0, 9) < 8);
      flush    = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 9) != 0);
      id_dst   = AW'($urandom_range(0, 7));
      id_wen   = ($urandom_range(0, 3) != 0);
      id_ld    = ($urandom_range(0, 9) < 3);
      src[0]   = AW'($urandom_range(0, 7));
      src[1]   = AW'($urandom_range(0, 7));
      used     = 2'($urandom_range(0, 3));
      rf[0]    = $urandom;
      rf[1]    = $urandom;
      ex_d     = $urandom;
      mem_d    = $urandom;
      wb_d     = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the 5-stage MIPS pipeline, sitting at the ID/EX boundary. It tracks destination tags of in-flight instructions internally, resolves each source operand of the ID-stage instruction to the youngest producer (EX, MEM, WB or register file), and raises a one-cycle stall on load-use dependencies. It adds an optional WB forwarding mode and a saturating stall counter.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 5, register index width
- NUM_SRC, 2, source operands per instruction (1..4)
- FWD_WB, 1, 1 = WB stage tracked and forwarded; 0 = only EX/MEM, regfile is write-before-read
- CNT_W, 32, stall counter width

- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- pipe_advance  in  1  global pipeline enable; 0 freezes all tag stages
- flush  in  1  kill ID instruction: bubble enters EX slot
- id_valid  in  1  ID-stage instruction valid
- id_src_idx  in  NUM_SRC*REG_AW  source register indices, src k at [k*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  per-source read enable
- id_dst  in  REG_AW  destination register
- id_wen  in  1  instruction writes id_dst
- id_is_load  in  1  instruction is a load
- id_src_data  in  NUM_SRC*DATA_W  register-file read data
- ex_alu_out  in  DATA_W  result of EX-stage instruction
- mem_out  in  DATA_W  result of MEM-stage instruction
- wb_data  in  DATA_W  result of WB-stage instruction (ignored if FWD_WB=0)
- opnd  out  NUM_SRC*DATA_W  resolved operands (combinational)
- fwd_sel  out  NUM_SRC*2  per-source select: 0 regfile, 1 EX, 2 MEM, 3 WB
- stall  out  1  load-use stall request (combinational)
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Tag pipeline: stages S1 (EX), S2 (MEM), S3 (WB, only if FWD_WB). Each holds {valid, dst, wen, is_load}.
- On clk with pipe_advance=1: S3<=S2, S2<=S1; S1<={id_valid & ~flush & ~stall, id_dst, id_wen, id_is_load}. With pipe_advance=0 all stages hold.
- Stage hit for source k: stage valid & wen & dst==src_idx[k] & dst!=0 & id_src_used[k].
- Select priority youngest first: S1 > S2 > S3 > regfile. Register 0 always resolves to regfile (sel 0).
- S1 hit on a load is not forwarded from EX (data not ready): stall=1 when id_valid & ~flush & any source hits S1 with is_load. fwd_sel for that source still reports the chosen lower-priority value; consumer ignores opnd while stall=1.
- During stall the ID instruction is held externally; a bubble enters S1, so next cycle the load sits in S2 and the operand resolves to MEM (sel 2).
- stall_cnt increments on cycles with stall & pipe_advance; saturates at all-ones, never wraps.
- opnd[k] = id_src_data / ex_alu_out / mem_out / wb_data per fwd_sel[k].

## Timing
- Reset (rst_n low, async): all stage valids 0, stall_cnt 0. Hence stall=0, fwd_sel=0, opnd=id_src_data while reset held or pipe empty.
- Forward selection, opnd and stall: zero latency (combinational from inputs and tag state).
- Tag state: one-cycle update per pipe_advance edge.
- flush and stall same cycle: flush wins, stall forced 0, bubble enters S1.
- pipe_advance=0 with pending load-use: stall stays 1, counter frozen.
- Reset mid-operation: all in-flight tags dropped immediately; first post-reset instruction resolves from regfile.

## Structure
- Package fwd_pkg: FWD_SEL_RF/EX/MEM/WB constants (2-bit), stage tag record {valid, dst, wen, is_load} width macro.
- Sub-module fwd_tag_pipe: parametrised tag shift register (depth 2 or 3 by FWD_WB), with advance/bubble inputs and per-stage tag outputs. Top instantiates it and a per-source generate loop for hit/priority/mux.

## Test plan
- add r3 then add r4,r3,r3 back-to-back, ex_alu_out=0x11 -> both fwd_sel=1, opnd=0x11, stall=0.
- lw r5 then add r6,r5,r1 -> cycle 1 stall=1, stall_cnt=1; cycle 2 fwd_sel[0]=2, opnd=mem_out=0xA5A5, stall=0.
- r3 written by S1 and S2 (mem_out=0x22, ex_alu_out=0x33) -> sel 1, opnd=0x33; S3 only, FWD_WB=1 -> sel 3; FWD_WB=0 -> sel 0.
- Instruction writing r0 followed by reader of r0 -> sel 0, opnd=id_src_data; load to r0 -> no stall.
- Load-use with pipe_advance=0 for 3 cycles -> stall held 1, stall_cnt unchanged, tags frozen; flush on same cycle -> stall=0, S1 bubble.
- CNT_W=4, 20 load-use stalls -> stall_cnt saturates at 15; assert rst_n mid-sequence -> stall_cnt=0, fwd_sel=0 immediately.
